// File: rtl/axi_stream_egress_demux_if.sv
// rtl/axi_stream_egress_demux_if.sv - stream bundle carrying NUM parallel lanes
// Lane n occupies bit n of tvalid/tready/tlast and slice n of tdata/tkeep/tuser.
interface axi_stream_egress_demux_if #(
  parameter int NUM    = 1,
  parameter int DATA_W = 32,
  parameter int USER_W = 16
);
  logic [NUM-1:0]          tvalid;
  logic [NUM-1:0]          tready;
  logic [NUM*DATA_W-1:0]   tdata;
  logic [NUM*DATA_W/8-1:0] tkeep;
  logic [NUM-1:0]          tlast;
  logic [NUM*USER_W-1:0]   tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axi_stream_egress_demux.sv
// rtl/axi_stream_egress_demux.sv - packet-atomic steering of one merged stream to N egress ports
// Head beat tuser = {vlan_id, port_id}; invalid port_id packets are swallowed and counted.
module axi_stream_egress_demux #(
  parameter int DATA_SIZE           = 32,
  parameter int USER_SIZE           = 16,
  parameter int PORT_ID_W           = 4,
  parameter int NUM_OF_EGRESS_PORTS = 3,
  parameter int CNT_W               = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  axi_stream_egress_demux_if.slave             s_axis,
  axi_stream_egress_demux_if.master            m_axis,
  output logic [NUM_OF_EGRESS_PORTS*CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0]                     drop_cnt
);
  localparam int NUM    = NUM_OF_EGRESS_PORTS;
  localparam int KEEP_W = DATA_SIZE / 8;
  localparam int VLAN_W = USER_SIZE - PORT_ID_W;
  localparam logic [PORT_ID_W:0] NUM_P = (PORT_ID_W + 1)'(NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [PORT_ID_W-1:0]   dest_q, cur_dest;
  logic [VLAN_W-1:0]      vlan_q, cur_vlan;
  logic                   dest_valid, drop_mode, blocked, s_ready, accept;
  logic [NUM-1:0]         sel, load;

  logic [NUM-1:0]         o_valid, o_last;
  logic [NUM*DATA_SIZE-1:0] o_data;
  logic [NUM*KEEP_W-1:0]  o_keep;
  logic [NUM*VLAN_W-1:0]  o_user;
  logic [NUM*CNT_W-1:0]   pkt_cnt_q;
  logic [CNT_W-1:0]       drop_cnt_q;

  // Routing fields come straight from tuser on the head beat, from the latch afterwards.
  assign cur_dest   = (state == IDLE) ? s_axis.tuser[PORT_ID_W-1:0] : dest_q;
  assign cur_vlan   = (state == IDLE) ? s_axis.tuser[USER_SIZE-1:PORT_ID_W] : vlan_q;
  assign dest_valid = ({1'b0, cur_dest} < NUM_P);
  assign drop_mode  = (state == DROP) || !dest_valid;

  always_comb begin
    sel     = '0;
    blocked = 1'b0;
    for (int p = 0; p < NUM; p++) begin
      if (dest_valid && (cur_dest == PORT_ID_W'(p))) begin
        sel[p]  = 1'b1;
        blocked = o_valid[p] && !m_axis.tready[p];
      end
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = !rst && (drop_mode || !blocked);
    accept     = s_axis.tvalid[0] && s_ready;
    load       = '0;
    if (accept && !drop_mode) begin
      load = sel;
    end
    case (state)
      IDLE: begin
        if (accept && !s_axis.tlast[0]) begin
          state_next = dest_valid ? FWD : DROP;
        end
      end
      FWD, DROP: begin
        if (accept && s_axis.tlast[0]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dest_q <= '0;
      vlan_q <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && accept) begin
        dest_q <= cur_dest;
        vlan_q <= cur_vlan;
      end
    end
  end

  // One-beat skid-free output stage per port; a load in the drain cycle keeps tvalid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= '0;
      o_last     <= '0;
      o_data     <= '0;
      o_keep     <= '0;
      o_user     <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NUM; p++) begin
        if (load[p]) begin
          o_valid[p]                          <= 1'b1;
          o_last[p]                           <= s_axis.tlast[0];
          o_data[p*DATA_SIZE +: DATA_SIZE]    <= s_axis.tdata;
          o_keep[p*KEEP_W +: KEEP_W]          <= s_axis.tkeep;
          o_user[p*VLAN_W +: VLAN_W]          <= cur_vlan;
          if (s_axis.tlast[0]) begin
            pkt_cnt_q[p*CNT_W +: CNT_W] <= pkt_cnt_q[p*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end else if (m_axis.tready[p]) begin
          o_valid[p] <= 1'b0;
        end
      end
      if (accept && drop_mode && s_axis.tlast[0]) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = o_valid;
  assign m_axis.tlast  = o_last;
  assign m_axis.tdata  = o_data;
  assign m_axis.tkeep  = o_keep;
  assign m_axis.tuser  = o_user;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_axi_stream_egress_demux.sv
// tb/tb_axi_stream_egress_demux.sv - scoreboard bench for axi_stream_egress_demux
`timescale 1ns/1ps
module tb_axi_stream_egress_demux;
  localparam int NUM = 3;
  localparam int DW  = 32;
  localparam int UW  = 16;
  localparam int PW  = 4;
  localparam int VW  = UW - PW;
  localparam int CW  = 32;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic [3:0]    keep;
    logic          last;
    logic [VW-1:0] vlan;
    int            cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM*CW-1:0] pkt_cnt;
  logic [CW-1:0]     drop_cnt;

  axi_stream_egress_demux_if #(.NUM(1),   .DATA_W(DW), .USER_W(UW)) s_if ();
  axi_stream_egress_demux_if #(.NUM(NUM), .DATA_W(DW), .USER_W(VW)) m_if ();

  axi_stream_egress_demux #(
    .DATA_SIZE(DW), .USER_SIZE(UW), .PORT_ID_W(PW),
    .NUM_OF_EGRESS_PORTS(NUM), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pkt_seq  = 0;
  bit check_lat = 1'b0;
  beat_t exp_q[$];
  logic [CW-1:0] exp_pkt [NUM];
  logic [CW-1:0] exp_drop;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every handshake on an egress port must match the oldest expected beat for that port.
  always @(negedge clk) begin
    int    found;
    beat_t e;
    for (int p = 0; p < NUM; p++) begin
      if (m_if.tvalid[p] === 1'b1 && m_if.tready[p] === 1'b1) begin
        found = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (found < 0 && exp_q[i].port == p) found = i;
        end
        n_checks++;
        if (found < 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_beat: port %0d got data %h, required no beat", p, m_if.tdata[p*DW +: DW]);
        end else begin
          e = exp_q[found];
          exp_q.delete(found);
          if (m_if.tdata[p*DW +: DW] !== e.data || m_if.tkeep[p*4 +: 4] !== e.keep ||
              m_if.tlast[p] !== e.last || m_if.tuser[p*VW +: VW] !== e.vlan) begin
            n_fail++;
            $display("FAIL sb_beat_port%0d: got data %h keep %h last %b vlan %h, required data %h keep %h last %b vlan %h",
                     p, m_if.tdata[p*DW +: DW], m_if.tkeep[p*4 +: 4], m_if.tlast[p], m_if.tuser[p*VW +: VW],
                     e.data, e.keep, e.last, e.vlan);
          end
          if (check_lat) begin
            n_checks++;
            if (cyc != e.cyc + 1) begin
              n_fail++;
              $display("FAIL sb_latency_port%0d: got %0d cycles, required 1", p, cyc - e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic send_pkt(input logic [PW-1:0] pid, input logic [VW-1:0] vlan,
                          input int nbeats, input int nsend, output int max_stall);
    int    stall;
    bit    accepted;
    beat_t e;
    max_stall = 0;
    pkt_seq++;
    for (int b = 0; b < nsend; b++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = {8'(pid), 8'(b), 16'(pkt_seq)};
      s_if.tkeep  = (b == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      s_if.tlast  = (b == nbeats - 1);
      s_if.tuser  = (b == 0) ? {vlan, pid} : 16'($urandom);
      stall    = 0;
      accepted = 1'b0;
      while (!accepted && stall < 200) begin
        @(negedge clk);
        if (s_if.tready[0] === 1'b1) accepted = 1'b1;
        else stall++;
      end
      if (!accepted) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: beat %0d to port %0d got no accept, required accept within 200 cycles", b, pid);
      end else if (pid < NUM) begin
        e.port = int'(pid);
        e.data = s_if.tdata;
        e.keep = s_if.tkeep;
        e.last = s_if.tlast[0];
        e.vlan = vlan;
        e.cyc  = cyc;
        exp_q.push_back(e);
        if (s_if.tlast[0]) exp_pkt[int'(pid)] = exp_pkt[int'(pid)] + 1;
      end else if (s_if.tlast[0]) begin
        exp_drop = exp_drop + 1;
      end
      if (stall > max_stall) max_stall = stall;
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain(output int left);
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    left = exp_q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model;
    for (int p = 0; p < NUM; p++) exp_pkt[p] = '0;
    exp_drop = '0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (s_if.tready[0] !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready: got %b, required 0", s_if.tready[0]); end
    n_checks++;
    if (m_if.tvalid !== 3'b000) begin n_fail++; $display("FAIL reset_m_tvalid: got %b, required 000", m_if.tvalid); end
    n_checks++;
    if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== '0) begin
      n_fail++;
      $display("FAIL reset_m_payload: got %h, required 0", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser});
    end
    n_checks++;
    if (pkt_cnt !== '0 || drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got pkt %h drop %h, required 0", pkt_cnt, drop_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_if.tready[0] !== 1'b1) begin n_fail++; $display("FAIL idle_s_tready: got %b, required 1", s_if.tready[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int st0, st1, st2, left;
    check_lat = 1'b1;
    send_pkt(4'd0, 12'h101, 4, 4, st0);
    send_pkt(4'd1, 12'h202, 4, 4, st1);
    send_pkt(4'd2, 12'h303, 4, 4, st2);
    wait_drain(left);
    check_lat = 1'b0;
    n_checks++;
    if (left != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d outstanding, required 0", left); end
    n_checks++;
    if (st0 + st1 + st2 != 0) begin n_fail++; $display("FAIL b2b_throughput: got %0d stall cycles, required 0", st0 + st1 + st2); end
    for (int p = 0; p < NUM; p++) begin
      n_checks++;
      if (pkt_cnt[p*CW +: CW] !== exp_pkt[p]) begin
        n_fail++;
        $display("FAIL b2b_pkt_cnt%0d: got %0d, required %0d", p, pkt_cnt[p*CW +: CW], exp_pkt[p]);
      end
    end
  endtask

  task automatic test_backpressure;
    int st, left;
    logic [DW-1:0] hold;
    hold = {8'd1, 8'd0, 16'(pkt_seq + 1)};
    m_if.tready[1] = 1'b0;
    fork
      send_pkt(4'd1, 12'h0b1, 3, 3, st);
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          n_checks++;
          if (m_if.tvalid[1] !== 1'b1 || m_if.tdata[DW +: DW] !== hold) begin
            n_fail++;
            $display("FAIL bp_hold: got valid %b data %h, required valid 1 data %h", m_if.tvalid[1], m_if.tdata[DW +: DW], hold);
          end
          n_checks++;
          if (s_if.tready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_s_tready: got %b, required 0", s_if.tready[0]); end
        end
        @(posedge clk);
        #1;
        m_if.tready[1] = 1'b1;
      end
    join
    wait_drain(left);
    n_checks++;
    if (left != 0 || pkt_cnt[CW +: CW] !== exp_pkt[1]) begin
      n_fail++;
      $display("FAIL bp_result: got left %0d pkt_cnt1 %0d, required left 0 pkt_cnt1 %0d", left, pkt_cnt[CW +: CW], exp_pkt[1]);
    end
  endtask

  task automatic test_atomicity;
    int st, left;
    bit tx_done, a_last_out, viol;
    tx_done = 1'b0; a_last_out = 1'b0; viol = 1'b0;
    fork
      begin
        send_pkt(4'd0, 12'h0aa, 5, 5, st);
        send_pkt(4'd2, 12'h0bb, 3, 3, st);
        tx_done = 1'b1;
      end
      begin
        for (int i = 0; i < 400 && !tx_done; i++) begin
          m_if.tready[0] = ~m_if.tready[0];
          @(posedge clk);
          #1;
        end
        m_if.tready[0] = 1'b1;
      end
      begin
        for (int i = 0; i < 400 && !tx_done; i++) begin
          @(negedge clk);
          if (m_if.tvalid[0] === 1'b1 && m_if.tlast[0] === 1'b1) a_last_out = 1'b1;
          if (m_if.tvalid[2] === 1'b1 && !a_last_out) viol = 1'b1;
        end
      end
    join
    wait_drain(left);
    n_checks++;
    if (viol) begin n_fail++; $display("FAIL atomic_order: got port 2 beat before pkt A tlast, required none"); end
    n_checks++;
    if (left != 0 || pkt_cnt[0 +: CW] !== exp_pkt[0] || pkt_cnt[2*CW +: CW] !== exp_pkt[2]) begin
      n_fail++;
      $display("FAIL atomic_result: got left %0d cnt0 %0d cnt2 %0d, required 0 %0d %0d",
               left, pkt_cnt[0 +: CW], pkt_cnt[2*CW +: CW], exp_pkt[0], exp_pkt[2]);
    end
  endtask

  task automatic test_drop;
    int st, left;
    send_pkt(4'd7, 12'h777, 6, 6, st);
    n_checks++;
    if (st != 0) begin n_fail++; $display("FAIL drop_s_tready: got %0d stall cycles, required 0", st); end
    n_checks++;
    if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, exp_drop); end
    n_checks++;
    if (m_if.tvalid !== 3'b000) begin n_fail++; $display("FAIL drop_m_tvalid: got %b, required 000", m_if.tvalid); end
    send_pkt(4'd3, 12'h333, 1, 1, st);
    n_checks++;
    if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL drop_cnt_1beat: got %0d, required %0d", drop_cnt, exp_drop); end
    send_pkt(4'd0, 12'h0cc, 2, 2, st);
    wait_drain(left);
    n_checks++;
    if (left != 0 || pkt_cnt[0 +: CW] !== exp_pkt[0]) begin
      n_fail++;
      $display("FAIL drop_next_pkt: got left %0d cnt0 %0d, required 0 %0d", left, pkt_cnt[0 +: CW], exp_pkt[0]);
    end
  endtask

  task automatic test_single_beat;
    int st, left;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    check_lat = 1'b1;
    send_pkt(4'd2, 12'h021, 1, 1, st);
    send_pkt(4'd0, 12'h022, 1, 1, st);
    send_pkt(4'd2, 12'h023, 1, 1, st);
    wait_drain(left);
    check_lat = 1'b0;
    n_checks++;
    if (left != 0) begin n_fail++; $display("FAIL single_drain: got %0d outstanding, required 0", left); end
    for (int p = 0; p < NUM; p++) begin
      n_checks++;
      if (pkt_cnt[p*CW +: CW] !== exp_pkt[p]) begin
        n_fail++;
        $display("FAIL single_pkt_cnt%0d: got %0d, required %0d", p, pkt_cnt[p*CW +: CW], exp_pkt[p]);
      end
    end
  endtask

  task automatic test_reset_mid_pkt;
    int st, left;
    send_pkt(4'd0, 12'h0dd, 8, 3, st);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    n_checks++;
    if (m_if.tvalid !== 3'b000) begin n_fail++; $display("FAIL midrst_m_tvalid: got %b, required 000", m_if.tvalid); end
    n_checks++;
    if (pkt_cnt !== '0 || drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL midrst_counters: got pkt %h drop %h, required 0", pkt_cnt, drop_cnt);
    end
    send_pkt(4'd2, 12'h0ee, 5, 5, st);
    wait_drain(left);
    n_checks++;
    if (left != 0 || pkt_cnt[2*CW +: CW] !== exp_pkt[2] || pkt_cnt[0 +: CW] !== exp_pkt[0]) begin
      n_fail++;
      $display("FAIL midrst_new_head: got left %0d cnt0 %0d cnt2 %0d, required 0 %0d %0d",
               left, pkt_cnt[0 +: CW], pkt_cnt[2*CW +: CW], exp_pkt[0], exp_pkt[2]);
    end
  endtask

  initial begin
    s_if.tvalid = '0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = '0;
    s_if.tuser  = '0;
    m_if.tready = '1;
    reset_model();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_atomicity();
    test_drop();
    test_single_beat();
    test_reset_mid_pkt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
